// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU DM stage and an external requester.
// The CPU wins by default; a starvation counter forces one external cycle after MAX_WAIT losses.
module dm_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic       cpu_act;
  logic       ext_win;
  logic       cpu_own;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  logic       ext_rd_reg;
  logic       ext_rd_next;

  always_comb begin
    cpu_act = cpu_re | cpu_we;
    ext_win = ext_req & (~cpu_act | (wait_cnt_reg >= WAIT_LIMIT));
    cpu_own = cpu_act & ~ext_win;
  end

  assign ext_gnt   = ext_win;
  assign cpu_stall = ext_win & cpu_act;

  // A simultaneous CPU load+store is a store; the load request is dropped.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_own) begin
      mem_we    = cpu_we;
      mem_re    = cpu_re & ~cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_win) begin
      mem_we    = ext_we;
      mem_re    = ~ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (ext_req && !ext_win && (wait_cnt_reg < WAIT_LIMIT))
      wait_cnt_next = wait_cnt_reg + 4'd1;
    else if (ext_req && !ext_win)
      wait_cnt_next = wait_cnt_reg;
    ext_rd_next = ext_win & ~ext_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      ext_rd_reg   <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      ext_rd_reg   <= ext_rd_next;
    end
  end

  // Read data is shared; the CPU consumes it in DM_WB, the requester on ext_rvalid.
  assign ext_rvalid = ext_rd_reg;
  assign ext_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural synchronous-read memory attached.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr;
  logic [31:0] ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_model [0:255];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr[7:0]];
  end

  dm_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    vec_cnt++;
    if ({ext_rvalid, cpu_stall, ext_gnt, mem_re, mem_we} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs got rv/st/gnt/re/we=%b required 00000",
               {ext_rvalid, cpu_stall, ext_gnt, mem_re, mem_we});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    $display("reset: released");
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    #1;
    vec_cnt++;
    if ({mem_we, mem_re, cpu_stall} !== 3'b100 || mem_addr !== 16'h0010 || mem_wdata !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL cpu_store got we/re/st=%b addr=%h data=%h required 100 0010 deadbeef",
               {mem_we, mem_re, cpu_stall}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 0; cpu_re = 1;
    #1;
    vec_cnt++;
    if ({mem_we, mem_re, cpu_stall} !== 3'b010 || mem_addr !== 16'h0010) begin
      err_cnt++;
      $display("FAIL cpu_load got we/re/st=%b addr=%h required 010 0010",
               {mem_we, mem_re, cpu_stall}, mem_addr);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vec_cnt++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL cpu_rdata got %h required deadbeef", cpu_rdata);
    end
    $display("cpu_only: store+load 0x0010");
  endtask

  task automatic test_ext_idle();
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_addr = 16'h0020; ext_wdata = 32'h12345678;
    #1;
    vec_cnt++;
    if ({ext_gnt, mem_we, mem_re, cpu_stall} !== 4'b1100 || mem_addr !== 16'h0020) begin
      err_cnt++;
      $display("FAIL ext_write got gnt/we/re/st=%b addr=%h required 1100 0020",
               {ext_gnt, mem_we, mem_re, cpu_stall}, mem_addr);
    end
    @(negedge clk);
    ext_we = 0;
    #1;
    vec_cnt++;
    if ({ext_gnt, mem_we, mem_re} !== 3'b101 || ext_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL ext_read_gnt got gnt/we/re=%b rvalid=%b required 101 0",
               {ext_gnt, mem_we, mem_re}, ext_rvalid);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vec_cnt++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin
      err_cnt++;
      $display("FAIL ext_rvalid got rv=%b data=%h required 1 12345678", ext_rvalid, ext_rdata);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (ext_rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL ext_rvalid_pulse got %b required 0", ext_rvalid);
    end
    $display("ext_idle: write+read 0x0020");
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      cpu_re = (c < 10); cpu_addr = 16'h0010;
      ext_req = (c < 10); ext_addr = 16'h0030;
      ext_we = (c < 5); ext_wdata = 32'hA5A50001;
      #1;
      if (c == 4 || c == 9) begin
        vec_cnt++;
        if ({ext_gnt, cpu_stall} !== 2'b11 || mem_addr !== 16'h0030 || mem_we !== (c == 4) || mem_re !== (c == 9)) begin
          err_cnt++;
          $display("FAIL starve_force c=%0d got gnt/st=%b addr=%h we=%b re=%b required 11 0030",
                   c, {ext_gnt, cpu_stall}, mem_addr, mem_we, mem_re);
        end
      end else if (c < 10) begin
        vec_cnt++;
        if ({ext_gnt, cpu_stall, mem_re, mem_we} !== 4'b0010 || mem_addr !== 16'h0010) begin
          err_cnt++;
          $display("FAIL starve_cpu c=%0d got gnt/st/re/we=%b addr=%h required 0010 0010",
                   c, {ext_gnt, cpu_stall, mem_re, mem_we}, mem_addr);
        end
      end else begin
        vec_cnt++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hA5A50001) begin
          err_cnt++;
          $display("FAIL starve_rdata got rv=%b data=%h required 1 a5a50001", ext_rvalid, ext_rdata);
        end
      end
    end
    idle_inputs();
    $display("starvation: forced grants at cycles 4 and 9");
  endtask

  task automatic test_simul_rw();
    @(negedge clk);
    cpu_re = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 32'hCAFEF00D;
    #1;
    vec_cnt++;
    if ({mem_we, mem_re} !== 2'b10 || mem_wdata !== 32'hCAFEF00D) begin
      err_cnt++;
      $display("FAIL simul_rw got we/re=%b data=%h required 10 cafef00d", {mem_we, mem_re}, mem_wdata);
    end
    @(negedge clk);
    cpu_we = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    vec_cnt++;
    if (cpu_rdata !== 32'hCAFEF00D) begin
      err_cnt++;
      $display("FAIL simul_rdata got %h required cafef00d", cpu_rdata);
    end
    $display("simul_rw: store wins at 0x0040");
  endtask

  task automatic test_withdraw();
    // Two losing cycles, one cycle withdrawn, then a fresh request must lose four more times.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cpu_re = 1; cpu_addr = 16'h0040;
      ext_req = (c != 2); ext_we = 1; ext_addr = 16'h0050; ext_wdata = 32'h0BADF00D;
      #1;
      vec_cnt++;
      if (c == 7) begin
        if ({ext_gnt, cpu_stall, mem_we} !== 3'b111) begin
          err_cnt++;
          $display("FAIL withdraw_force got gnt/st/we=%b required 111", {ext_gnt, cpu_stall, mem_we});
        end
      end else if ({ext_gnt, cpu_stall, mem_we, mem_re} !== 4'b0001) begin
        err_cnt++;
        $display("FAIL withdraw_wait c=%0d got gnt/st/we/re=%b required 0001",
                 c, {ext_gnt, cpu_stall, mem_we, mem_re});
      end
    end
    idle_inputs();
    $display("withdraw: counter restarted after drop");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ext_req = (c < 2); ext_we = 0; ext_addr = (c == 0) ? 16'h0020 : 16'h0030;
      #1;
      vec_cnt++;
      if (ext_gnt !== (c < 2) || ext_rvalid !== (c == 1 || c == 2)) begin
        err_cnt++;
        $display("FAIL b2b_ctrl c=%0d got gnt=%b rv=%b", c, ext_gnt, ext_rvalid);
      end
      if (c == 1 || c == 2) begin
        vec_cnt++;
        if (ext_rdata !== ((c == 1) ? 32'h12345678 : 32'hA5A50001)) begin
          err_cnt++;
          $display("FAIL b2b_data c=%0d got %h", c, ext_rdata);
        end
      end
    end
    idle_inputs();
    $display("back_to_back: reads 0x0020, 0x0030");
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_addr = 16'h0020;
    @(posedge clk);
    #1;
    idle_inputs();
    vec_cnt++;
    if (ext_rvalid !== 1'b1) begin
      err_cnt++;
      $display("FAIL midop_pre got rvalid=%b required 1", ext_rvalid);
    end
    rst_n = 0;
    #1;
    vec_cnt++;
    if ({ext_rvalid, cpu_stall, mem_we} !== 3'b000) begin
      err_cnt++;
      $display("FAIL midop_reset got rv/st/we=%b required 000", {ext_rvalid, cpu_stall, mem_we});
    end
    @(negedge clk);
    rst_n = 1;
    $display("reset_midop: rvalid cleared asynchronously");
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_ext_idle();
    test_starvation();
    test_simul_rw();
    test_withdraw();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Single-port data-memory arbiter that shares the data memory between the CPU pipeline's DM-stage loads/stores and an external requester (image loader / accelerator port). The CPU normally has priority with zero added latency. A starvation counter guarantees the external port service within a bounded number of cycles by stalling the CPU for one cycle. The block sits between the EX_DM pipeline registers (dm_re_EX_DM / dm_we_EX_DM) and the data-memory macro.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 32, memory data width
- MAX_WAIT, 4, max consecutive cycles an external request may lose to the CPU; legal range 1..15

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_re  in  1  CPU load request (dm_re_EX_DM)
- cpu_we  in  1  CPU store request (dm_we_EX_DM)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data
- cpu_stall  out  1  CPU access not serviced this cycle; pipeline must hold the DM request
- ext_req  in  1  external access request, held high until ext_gnt
- ext_we  in  1  external write (1) / read (0), qualified by ext_req
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_gnt  out  1  external access performed this cycle
- ext_rdata  out  DATA_W  external read data
- ext_rvalid  out  1  ext_rdata valid (one cycle after a granted read)
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, synchronous, valid the cycle after mem_re

## Operation
- cpu_act = cpu_re | cpu_we. Both high: treated as write; cpu_re ignored.
- Starvation counter wait_cnt (4 bits), registered.
- Grant decision each cycle (combinational from inputs and wait_cnt):
  - !ext_req: CPU owns port if cpu_act; ext_gnt=0; cpu_stall=0.
  - ext_req & !cpu_act: external owns port; ext_gnt=1.
  - ext_req & cpu_act & wait_cnt<MAX_WAIT: CPU owns port; ext_gnt=0; cpu_stall=0.
  - ext_req & cpu_act & wait_cnt==MAX_WAIT: external owns port; ext_gnt=1; cpu_stall=1.
- wait_cnt next: 0 when ext_gnt or !ext_req; wait_cnt+1 when ext_req loses to CPU. It never exceeds MAX_WAIT.
- Memory port: mem_re/mem_we/mem_addr/mem_wdata driven from the owner. No owner: mem_re=mem_we=0, addr/wdata=0.
- Read return: registered flag ext_rd_q <= ext_gnt & !ext_we. ext_rvalid = ext_rd_q. ext_rdata = mem_rdata. cpu_rdata = mem_rdata, used by the pipeline in the DM_WB stage.
- After a forced external cycle wait_cnt=0, so the held CPU request wins the next cycle.

## Timing
- Reset values: wait_cnt=0, ext_rd_q=0, so ext_rvalid=0. With all requests low, combinational outputs are cpu_stall=0, ext_gnt=0, mem_re=mem_we=0.
- CPU latency: zero added. Request cycle N goes to memory in N; load data arrives at N+1. A forced stall adds exactly 1 cycle.
- External latency: grant in the request cycle if the CPU is idle, otherwise at most MAX_WAIT+1 cycles after ext_req rises.
- ext_rvalid is high exactly one cycle, the cycle after a granted external read. Back-to-back granted reads give back-to-back ext_rvalid.
- Asynchronous reset mid-operation clears wait_cnt and ext_rd_q immediately. An in-flight external read loses its rvalid; the requester must reissue.
- ext_req dropped before grant: wait_cnt clears next edge; no memory access occurs.

## Test plan
- Reset: assert rst_n=0 with ext_rd_q previously 1 -> ext_rvalid=0 immediately, cpu_stall=0, mem_we=0.
- CPU only: cpu_we=1, addr 0x0010, data 0xDEADBEEF; then cpu_re=1, same addr -> mem_we in cycle 0; cpu_rdata=0xDEADBEEF at cycle 2; cpu_stall never high.
- External on idle CPU: ext_req=1, ext_we=0, addr 0x0020 -> ext_gnt same cycle; ext_rvalid next cycle with memory contents.
- Starvation bound, MAX_WAIT=4: cpu_re held high continuously, ext_req rises at cycle 0 -> CPU served cycles 0-3; cycle 4 ext_gnt=1, cpu_stall=1; cycle 5 CPU served, wait_cnt=0.
- Simultaneous re+we from CPU: cpu_re=cpu_we=1 -> mem_we=1, mem_re=0.
- Request withdrawn: ext_req high 2 cycles under CPU load, then low -> no ext_gnt; wait_cnt back to 0; a new ext_req waits the full MAX_WAIT again.
